led_pwm_ramp: RTL and testbench
===============================

LED_PWM_RAMP -- requirements
Module: led_pwm_ramp

Interface
REQ-001 Parameter RAMP_DIV, default 1000, clock cycles per ramp tick; legal range 1..65535.
REQ-002 Parameter STEP, default 4, duty increment/decrement per ramp tick; legal range 1..255.
REQ-003 i_clk  input  1  sole clock; all state on rising edge.
REQ-004 i_reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 i_level  input  3  requested light level from the LED state FSM; 0..4 valid, 5..7 invalid.
REQ-006 o_pwm  output  1  LED drive, high = on.
REQ-007 o_duty  output  8  current ramped duty value.
REQ-008 o_busy  output  1  high while the ramp is moving toward the target.

Function
REQ-009 The block SHALL register i_level into level_q every cycle, giving 1 cycle input latency.
REQ-010 Target decode from level_q SHALL be 0->0, 1->64, 2->128, 3->192, 4->255; codes 5..7 SHALL decode to 0.
REQ-011 Prescaler div_cnt SHALL count 0..RAMP_DIV-1 and wrap; tick is high for the one cycle where div_cnt==RAMP_DIV-1; RAMP_DIV=1 gives a tick every cycle.
REQ-012 On tick with duty<target, duty SHALL become min(duty+STEP, target), using 9-bit arithmetic with no wrap past 255.
REQ-013 On tick with duty>target, duty SHALL become max(duty-STEP, target), with no underflow below 0.
REQ-014 On tick with duty==target, or on any non-tick cycle, duty SHALL hold.
REQ-015 The FSM SHALL have states IDLE, RAMP_UP, and RAMP_DOWN, re-evaluated every cycle as follows:
- target>duty -> RAMP_UP
- target<duty -> RAMP_DOWN
- otherwise -> IDLE
REQ-016 A target change mid-ramp SHALL redirect the ramp from the current duty; there is no restart and no jump.
REQ-017 o_busy SHALL be high exactly when the state is not IDLE.
REQ-018 PWM counter pwm_cnt SHALL count 0..254 and wrap, giving a 255-cycle period.
REQ-019 duty SHALL be copied to shadow register duty_sh on the cycle pwm_cnt==254, so a new value takes effect from the next period start (pwm_cnt==0).
REQ-020 o_pwm SHALL be registered and equal to (pwm_cnt < duty_sh) from the prior cycle, i.e. 1 cycle of output latency.
REQ-021 duty_sh=0 SHALL give o_pwm constantly 0; duty_sh=255 SHALL give o_pwm constantly 1.
REQ-022 o_duty SHALL equal the duty register, not duty_sh.

Reset
REQ-023 While i_reset_n=0, the block SHALL asynchronously force the following:
- level_q, duty, duty_sh, div_cnt, pwm_cnt = 0
- state = IDLE
- o_pwm = 0, o_duty = 0, o_busy = 0
REQ-024 After release, the block SHALL begin counting on the first rising edge.
REQ-025 Reset asserted mid-ramp SHALL abandon the ramp immediately, with no completion.
REQ-026 All registers SHALL be covered by reset; there SHALL be no X on any output after reset.

Verification (RAMP_DIV=2, STEP=4 unless stated)
REQ-027 Reset: assert i_reset_n=0 with i_level=4 -> o_pwm=0, o_duty=0, o_busy=0 held throughout reset.
REQ-028 Ramp up: i_level 0->4 held -> o_busy=1 from 2 cycles after the change (level_q, then FSM); o_duty steps 4,8,...,252,255 on every 2nd cycle; 255 is reached on the 64th tick; o_busy=0 the cycle after.
REQ-029 Ramp down with saturation: from duty 255, i_level=1 -> o_duty 251,...,67,64; it stops exactly at 64 with no undershoot; o_busy falls.
REQ-030 Reversal and invalid code:
- i_level=4 until o_duty=100, then i_level=6 -> direction reverses to down with no jump, and ramps to 0.
- Same sequence with i_level=0 -> identical result.
REQ-031 PWM accuracy (RAMP_DIV=1, STEP=255): i_level=2 -> after the next period boundary, each 255-cycle period has exactly 128 high cycles.
- i_level=0 -> 0 high cycles.
- i_level=4 -> 255 high cycles.
REQ-032 Reset mid-operation: pulse i_reset_n low while duty=120 and ramping -> all outputs 0 immediately; after release with i_level=3 held, the ramp restarts from 0 toward 192.

Source files
------------

// File: rtl/led_pwm_ramp_if.sv
// rtl/led_pwm_ramp_if.sv - level request and LED drive signals of the PWM ramp block
//
// Purpose: bundles the requested light level and the ramp/PWM outputs so the
//          block and its driver share one connection.
// Signals:
//   i_level [2:0]  requested light level (0..4 valid, 5..7 decode to off)
//   o_pwm          LED drive, high = on
//   o_duty  [7:0]  current ramped duty value
//   o_busy         high while the ramp is moving toward the target
// Modports:
//   master  drives i_level, observes the outputs
//   slave   the ramp block itself
interface led_pwm_ramp_if;
  logic [2:0] i_level;
  logic       o_pwm;
  logic [7:0] o_duty;
  logic       o_busy;

  modport master (
    output i_level,
    input  o_pwm,
    input  o_duty,
    input  o_busy
  );

  modport slave (
    input  i_level,
    output o_pwm,
    output o_duty,
    output o_busy
  );
endinterface

// File: rtl/led_pwm_ramp.sv
// rtl/led_pwm_ramp.sv - LED brightness ramp with shadowed 255-cycle PWM output
//
// Purpose: moves a duty value toward the target brightness of the requested
//          level in STEP increments every RAMP_DIV cycles, and drives an LED
//          with a PWM whose duty is reloaded only at period boundaries.
// Parameters:
//   RAMP_DIV  clock cycles per ramp tick (1..65535)
//   STEP      duty change per ramp tick (1..255)
// Ports:
//   i_clk      sole clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   bus        led_pwm_ramp_if.slave (i_level in; o_pwm, o_duty, o_busy out)
module led_pwm_ramp #(
  parameter int RAMP_DIV = 1000,
  parameter int STEP     = 4
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  led_pwm_ramp_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } state_t;

  localparam logic [15:0] DIV_MAX   = 16'(RAMP_DIV - 1);
  localparam logic [8:0]  STEP9     = 9'(STEP);
  localparam logic [7:0]  PWM_LAST  = 8'd254;

  logic [2:0]  level_q,   level_d;
  logic [7:0]  duty_q,    duty_d;
  logic [7:0]  duty_sh_q, duty_sh_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic        pwm_q,     pwm_d;
  state_t      state_q,   state_d;

  logic        tick;
  logic [7:0]  target;
  logic [8:0]  duty_up;
  logic [8:0]  duty_dn;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      level_q   <= 3'd0;
      duty_q    <= 8'd0;
      duty_sh_q <= 8'd0;
      div_cnt_q <= 16'd0;
      pwm_cnt_q <= 8'd0;
      pwm_q     <= 1'b0;
      state_q   <= IDLE;
    end else begin
      level_q   <= level_d;
      duty_q    <= duty_d;
      duty_sh_q <= duty_sh_d;
      div_cnt_q <= div_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      pwm_q     <= pwm_d;
      state_q   <= state_d;
    end
  end

  always_comb begin
    level_d   = bus.i_level;
    target    = 8'd0;
    tick      = (div_cnt_q == DIV_MAX);
    div_cnt_d = tick ? 16'd0 : div_cnt_q + 16'd1;
    duty_d    = duty_q;
    duty_up   = {1'b0, duty_q} + STEP9;
    duty_dn   = {1'b0, duty_q} - STEP9;
    state_d   = IDLE;
    pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? 8'd0 : pwm_cnt_q + 8'd1;
    duty_sh_d = duty_sh_q;
    pwm_d     = (pwm_cnt_q < duty_sh_q);

    case (level_q)
      3'd1:    target = 8'd64;
      3'd2:    target = 8'd128;
      3'd3:    target = 8'd192;
      3'd4:    target = 8'd255;
      default: target = 8'd0;
    endcase

    // 9-bit arithmetic: bit 8 of duty_up flags a sum past 255, bit 8 of
    // duty_dn flags a borrow below 0; either way the target clamps it.
    if (tick) begin
      if (duty_q < target) begin
        duty_d = (duty_up > {1'b0, target}) ? target : duty_up[7:0];
      end else if (duty_q > target) begin
        duty_d = (duty_dn[8] || (duty_dn[7:0] < target)) ? target : duty_dn[7:0];
      end
    end

    // Direction is recomputed from the live target every cycle, so a level
    // change mid-ramp redirects from the current duty without restarting.
    if (target > duty_q) begin
      state_d = RAMP_UP;
    end else if (target < duty_q) begin
      state_d = RAMP_DOWN;
    end

    // Reload on the last count so the new duty applies from count 0.
    if (pwm_cnt_q == PWM_LAST) begin
      duty_sh_d = duty_q;
    end
  end

  assign bus.o_pwm  = pwm_q;
  assign bus.o_duty = duty_q;
  assign bus.o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_led_pwm_ramp.sv
// tb/tb_led_pwm_ramp.sv - directed self-checking bench for led_pwm_ramp
module tb_led_pwm_ramp;

  localparam int DIV_A  = 2;
  localparam int STEP_A = 4;

  logic clk;
  logic rst_n;

  int n_pass;
  int n_total;

  led_pwm_ramp_if a_if ();
  led_pwm_ramp_if b_if ();

  led_pwm_ramp #(.RAMP_DIV(DIV_A), .STEP(STEP_A)) u_dut_a (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (a_if.slave)
  );

  led_pwm_ramp #(.RAMP_DIV(1), .STEP(255)) u_dut_b (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Follows dut A's duty from 'start' until it reaches stop_val, checking
  // every step against min/max(prev +/- STEP, target) and the tick spacing.
  task automatic follow_ramp(input string tag, input int start, input int target,
                             input int stop_val, input int exp_steps, input bit chk_lat);
    int prev;
    int cyc;
    int last;
    int nchg;
    int expv;
    bit done;
    prev = start;
    cyc  = 0;
    last = 0;
    nchg = 0;
    done = 1'b0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (chk_lat && cyc == 1) chk({tag, "_busy_lat1"}, 32'(a_if.o_busy), 0);
      if (chk_lat && cyc == 2) chk({tag, "_busy_lat2"}, 32'(a_if.o_busy), 1);
      if (int'(a_if.o_duty) != prev) begin
        if (target > prev) expv = (prev + STEP_A > target) ? target : prev + STEP_A;
        else               expv = (prev - STEP_A < target) ? target : prev - STEP_A;
        chk({tag, "_step"}, 32'(a_if.o_duty), expv);
        if (nchg > 0) chk({tag, "_gap"}, cyc - last, DIV_A);
        prev = int'(a_if.o_duty);
        last = cyc;
        nchg++;
        if (prev == stop_val) done = 1'b1;
      end
    end
    chk({tag, "_reached"}, prev, stop_val);
    chk({tag, "_nsteps"}, nchg, exp_steps);
    chk({tag, "_busy_at_stop"}, 32'(a_if.o_busy), 1);
    if (stop_val == target) begin
      @(negedge clk);
      chk({tag, "_busy_fall"}, 32'(a_if.o_busy), 0);
      chk({tag, "_hold"}, 32'(a_if.o_duty), stop_val);
    end
  endtask

  task automatic count_high(input string tag, input int exp_duty, input int exp_high);
    int highs;
    highs = 0;
    repeat (520) @(negedge clk);
    chk({tag, "_duty"}, 32'(b_if.o_duty), exp_duty);
    chk({tag, "_busy"}, 32'(b_if.o_busy), 0);
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      if (b_if.o_pwm === 1'b1) highs++;
    end
    chk({tag, "_highs"}, highs, exp_high);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;

    // Reset held with a valid level requested: everything stays at zero.
    rst_n        = 1'b0;
    a_if.i_level = 3'd4;
    b_if.i_level = 3'd4;
    #1;
    chk("rst_duty", 32'(a_if.o_duty), 0);
    chk("rst_busy", 32'(a_if.o_busy), 0);
    chk("rst_pwm", 32'(a_if.o_pwm), 0);
    repeat (4) begin
      @(negedge clk);
      chk("rst_hold_duty", 32'(a_if.o_duty), 0);
      chk("rst_hold_busy", 32'(a_if.o_busy), 0);
      chk("rst_hold_pwm", 32'(a_if.o_pwm), 0);
      chk("rst_hold_b_pwm", 32'(b_if.o_pwm), 0);
    end
    a_if.i_level = 3'd0;
    b_if.i_level = 3'd0;
    rst_n        = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_duty", 32'(a_if.o_duty), 0);
    chk("idle_busy", 32'(a_if.o_busy), 0);

    // Full ramp up to 255: 63 steps of 4 then a clamped final step.
    a_if.i_level = 3'd4;
    follow_ramp("up", 0, 255, 255, 64, 1'b1);

    // Ramp down to level 1 stopping exactly at 64.
    a_if.i_level = 3'd1;
    follow_ramp("down", 255, 64, 64, 48, 1'b1);

    // Back to zero before the reversal tests.
    a_if.i_level = 3'd0;
    follow_ramp("to_zero", 64, 0, 0, 16, 1'b1);

    // Reversal through invalid code 6.
    a_if.i_level = 3'd4;
    follow_ramp("rev6_up", 0, 255, 100, 25, 1'b0);
    a_if.i_level = 3'd6;
    follow_ramp("rev6_down", 100, 0, 0, 25, 1'b0);

    // Same reversal through code 0.
    a_if.i_level = 3'd4;
    follow_ramp("rev0_up", 0, 255, 100, 25, 1'b0);
    a_if.i_level = 3'd0;
    follow_ramp("rev0_down", 100, 0, 0, 25, 1'b0);

    // Reset pulse in the middle of a ramp toward 192.
    a_if.i_level = 3'd3;
    follow_ramp("pre_rst", 0, 192, 120, 30, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_duty", 32'(a_if.o_duty), 0);
    chk("midrst_busy", 32'(a_if.o_busy), 0);
    chk("midrst_pwm", 32'(a_if.o_pwm), 0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_hold_duty", 32'(a_if.o_duty), 0);
      chk("midrst_hold_busy", 32'(a_if.o_busy), 0);
    end
    rst_n = 1'b1;
    follow_ramp("restart", 0, 192, 192, 48, 1'b1);

    // PWM accuracy on the fast instance: any 255 consecutive cycles of a
    // settled output cover exactly one period.
    b_if.i_level = 3'd2;
    count_high("pwm_l2", 128, 128);
    b_if.i_level = 3'd0;
    count_high("pwm_l0", 0, 0);
    b_if.i_level = 3'd4;
    count_high("pwm_l4", 255, 255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
